// File: rtl/spi_reg_responder.sv
// SPI mode-0 register responder: 16-bit command frames with burst continuation.
// Optional SPI_WRITE_ECHO_EN: write data phases shift out the old register value on miso.
module spi_reg_responder #(
  parameter int         NUM_REGS    = 8,
  parameter logic [6:0] STATUS_ADDR = 7'h7F
) (
  input  logic                  sclk,
  input  logic                  rst,
  input  logic                  ss,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [7:0]            status_in,
  output logic [NUM_REGS*8-1:0] reg_out,
  output logic                  byte_toggle
);

  localparam logic [7:0] NUM_REGS_L = 8'(NUM_REGS);

  typedef enum logic {ST_CMD = 1'b0, ST_DATA = 1'b1} state_t;

  state_t      state_r, state_nxt_s;
  logic [2:0]  bit_cnt_r, bit_cnt_nxt_s;
  logic [6:0]  shift_r, shift_nxt_s;
  logic [6:0]  addr_r, addr_nxt_s;
  logic        rw_r, rw_nxt_s;
  logic [7:0]  regs_r [NUM_REGS];
  logic        toggle_r;
  logic        miso_r;
  logic [6:0]  miso_shift_r;
  logic [7:0]  rx_byte_s;
  logic [7:0]  rd_byte_s;
  logic        byte_done_s;
  logic        data_done_s;
  logic        load_en_s;

  assign rx_byte_s   = {shift_r, mosi};
  assign byte_done_s = (bit_cnt_r == 3'd7);
  assign data_done_s = byte_done_s && (state_r == ST_DATA) && !ss;

`ifdef SPI_WRITE_ECHO_EN
  assign load_en_s = 1'b1;
`else
  assign load_en_s = rw_r;
`endif

  // Frame sequencing: command byte, then data bytes with auto-incrementing address
  always_comb begin
    state_nxt_s   = state_r;
    bit_cnt_nxt_s = bit_cnt_r + 3'd1;
    shift_nxt_s   = rx_byte_s[6:0];
    addr_nxt_s    = addr_r;
    rw_nxt_s      = rw_r;
    if (byte_done_s) begin
      case (state_r)
        ST_CMD: begin
          rw_nxt_s    = rx_byte_s[7];
          addr_nxt_s  = rx_byte_s[6:0];
          state_nxt_s = ST_DATA;
        end
        ST_DATA: begin
          addr_nxt_s  = addr_r + 7'd1;
          state_nxt_s = ST_DATA;
        end
        default: state_nxt_s = ST_CMD;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Frame state register; ss high abandons the frame immediately
  always_ff @(posedge sclk or posedge rst or posedge ss) begin
    if (rst || ss) begin
      state_r   <= ST_CMD;
      bit_cnt_r <= 3'd0;
      shift_r   <= 7'd0;
      addr_r    <= 7'd0;
      rw_r      <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      shift_r   <= shift_nxt_s;
      addr_r    <= addr_nxt_s;
      rw_r      <= rw_nxt_s;
    end
  end

  // Register bank and byte-completion toggle survive ss, cleared only by rst
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_REGS; k++) regs_r[k] <= 8'h00;
      toggle_r <= 1'b0;
    end else if (data_done_s) begin
      toggle_r <= ~toggle_r;
      for (int k = 0; k < NUM_REGS; k++) begin
        if (!rw_r && (addr_r == 7'(k))) regs_r[k] <= rx_byte_s;
      end
    end
  end

  // Read source: bank, status, or zero for unmapped addresses
  always_comb begin
    rd_byte_s = 8'h00;
    if ({1'b0, addr_r} < NUM_REGS_L) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (addr_r == 7'(k)) rd_byte_s = regs_r[k];
        else rd_byte_s = rd_byte_s;
      end
    end else if (addr_r == STATUS_ADDR) begin
      rd_byte_s = status_in;
    end else begin
      rd_byte_s = 8'h00;
    end
  end

  // bit_cnt of 0 in DATA marks the negedge right after a byte boundary: load next byte
  always_ff @(negedge sclk or posedge rst or posedge ss) begin
    if (rst || ss) begin
      miso_r       <= 1'b0;
      miso_shift_r <= 7'd0;
    end else if ((state_r == ST_DATA) && (bit_cnt_r == 3'd0)) begin
      if (load_en_s) {miso_r, miso_shift_r} <= rd_byte_s;
      else           {miso_r, miso_shift_r} <= 8'h00;
    end else begin
      miso_r       <= miso_shift_r[6];
      miso_shift_r <= {miso_shift_r[5:0], 1'b0};
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
    assign reg_out[8*k +: 8] = regs_r[k];
  end

  assign miso        = miso_r;
  assign byte_toggle = toggle_r;

endmodule

// File: tb/tb_spi_reg_responder.sv
// Randomized self-checking bench for spi_reg_responder against a register-bank model.
module tb_spi_reg_responder;
  localparam int NR = 8;

  logic          sclk, rst, ss, mosi, miso, byte_toggle;
  logic [7:0]    status_in;
  logic [NR*8-1:0] reg_out;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mregs [NR];
  logic       mtog;
  logic [7:0] tx_data [4];
  logic [7:0] rx_last;
  bit         rst_abort = 1'b0;
  bit         echo;

  spi_reg_responder #(.NUM_REGS(NR), .STATUS_ADDR(7'h7F)) dut (
    .sclk(sclk), .rst(rst), .ss(ss), .mosi(mosi), .miso(miso),
    .status_in(status_in), .reg_out(reg_out), .byte_toggle(byte_toggle)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] mval(input logic [6:0] a);
    if (int'(a) < NR) return mregs[int'(a)];
    else if (a == 7'h7F) return status_in;
    else return 8'h00;
  endfunction

  function automatic logic [63:0] mflat();
    logic [63:0] f;
    f = 64'd0;
    for (int k = 0; k < NR; k++) f[8*k +: 8] = mregs[k];
    return f;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NR; k++) mregs[k] = 8'h00;
    mtog = 1'b0;
  endtask

  // One ss-low frame; stop>0 cuts it after that many bits
  task automatic frame(input logic [7:0] cmd, input int nbytes, input int stop);
    int total, d;
    logic [6:0] a;
    logic [7:0] cur_tx, cur_exp, rxs;
    a = 7'd0; cur_exp = 8'h00; rxs = 8'h00;
    ss = 1'b0;
    #5;
    total = (stop > 0) ? stop : 8 + 8 * nbytes;
    for (int i = 0; i < total; i++) begin
      if (i < 8) cur_tx = cmd;
      else begin
        d = (i - 8) / 8;
        cur_tx = tx_data[d];
        a = cmd[6:0] + 7'(d);
        if (i % 8 == 0) cur_exp = (cmd[7] || echo) ? mval(a) : 8'h00;
      end
      mosi = cur_tx[7 - (i % 8)];
      #2;
      if (i < 8) chk("miso_cmd", 64'(miso), 64'd0);
      else chk("miso_data", 64'(miso), 64'(cur_exp[7 - (i % 8)]));
      rxs = {rxs[6:0], miso};
      #3 sclk = 1'b1;
      #5 sclk = 1'b0;
      if (i >= 8 && i % 8 == 7) begin
        if (!cmd[7] && int'(a) < NR) mregs[int'(a)] = cur_tx;
        mtog = ~mtog;
        rx_last = rxs;
        chk("reg_out", reg_out, mflat());
        chk("byte_toggle", 64'(byte_toggle), 64'(mtog));
      end
    end
    if (rst_abort) begin
      rst = 1'b1;
      #1;
      model_reset();
      chk("rst_miso", 64'(miso), 64'd0);
      chk("rst_reg_out", reg_out, 64'd0);
      chk("rst_toggle", 64'(byte_toggle), 64'd0);
      #4 rst = 1'b0;
      rst_abort = 1'b0;
    end
    #5 ss = 1'b1;
    #5;
    chk("idle_miso", 64'(miso), 64'd0);
    chk("idle_reg_out", reg_out, mflat());
    chk("idle_toggle", 64'(byte_toggle), 64'(mtog));
  endtask

  initial begin
`ifdef SPI_WRITE_ECHO_EN
    echo = 1'b1;
`else
    echo = 1'b0;
`endif
    sclk = 1'b0; rst = 1'b1; ss = 1'b1; mosi = 1'b0; status_in = 8'h00;
    model_reset();
    #10;
    chk("reset_reg_out", reg_out, 64'd0);
    chk("reset_toggle", 64'(byte_toggle), 64'd0);
    chk("reset_miso", 64'(miso), 64'd0);
    rst = 1'b0;
    #10;

    tx_data[0] = 8'hEE;
    frame(8'h03, 1, 0);
    chk("pin_write3", reg_out, 64'h00000000_EE000000);
    chk("pin_tog1", 64'(byte_toggle), 64'd1);

    tx_data[0] = 8'h00;
    frame(8'h83, 1, 0);
    chk("pin_read3", 64'(rx_last), 64'hEE);

    status_in = 8'hA5;
    frame(8'hFF, 1, 0);
    chk("pin_status", 64'(rx_last), 64'hA5);
    tx_data[0] = 8'h12;
    frame(8'h7F, 1, 0);
    chk("pin_status_wr", reg_out, 64'h00000000_EE000000);
    chk("pin_tog4", 64'(byte_toggle), 64'd0);

    tx_data[0] = 8'h11; tx_data[1] = 8'h22; tx_data[2] = 8'h33;
    frame(8'h06, 3, 0);
    chk("pin_burst", reg_out, 64'h2211_0000_EE00_0000);

    tx_data[0] = 8'h5A;
    frame(8'h01, 1, 12);
    chk("pin_abort", reg_out, 64'h2211_0000_EE00_0000);
    frame(8'h01, 1, 0);
    chk("pin_after_abort", reg_out, 64'h2211_0000_EE00_5A00);

    tx_data[0] = 8'h00;
    rst_abort = 1'b1;
    frame(8'h83, 1, 12);
    frame(8'h83, 1, 0);
    chk("pin_read_after_rst", 64'(rx_last), 64'h00);

    for (int it = 0; it < 40; it++) begin
      logic [6:0] ad;
      logic [7:0] cmd;
      int nb, stop;
      ad = ($urandom % 2 == 0) ? 7'($urandom_range(0, 9)) : 7'($urandom_range(120, 127));
      cmd = {1'($urandom), ad};
      nb = $urandom_range(1, 3);
      for (int k = 0; k < 4; k++) tx_data[k] = 8'($urandom);
      stop = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 8 + 8 * nb - 1) : 0;
      status_in = 8'($urandom);
      frame(cmd, nb, stop);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
